// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared types and defaults for the push-button conditioner.
// The channel state enum and default timing constants live here so the top
// and the per-channel debouncer agree on them.
package btn_cond_pkg;

  // Debounce state of one button channel
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } btn_state_t;

  // 20 ms stable time at 100 MHz
  localparam int unsigned DB_CYCLES_DEF     = 2_000_000;
  // 500 ms from press to first auto-repeat at 100 MHz
  localparam int unsigned REPEAT_DELAY_DEF  = 50_000_000;
  // 100 ms between auto-repeats at 100 MHz
  localparam int unsigned REPEAT_PERIOD_DEF = 10_000_000;

  // Larger of two unsigned values, used to size the repeat counter
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button pins in, debounced level and press/release
// pulses out. The slave modport is the conditioner's view; master is the
// view of whatever drives the pins and consumes the events.
interface btn_conditioner_if #(
  parameter int unsigned N_BTN = 6
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel. 2-FF synchroniser, four-state
// debounce FSM with a saturating stable-sample counter, registered outputs.
// Optional auto-repeat of btn_press while held is compiled in with the
// BTN_COND_REPEAT_EN macro.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF
`ifdef BTN_COND_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DB_CYCLES);

  logic             r_s0;
  logic             r_s1;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_rep_fire;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_raw;
      r_s1 <= r_s0;
    end
  end

`ifdef BTN_COND_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;

  // Fire only while staying in HIGH; a falling sample leaves HIGH instead
  assign w_rep_fire = (r_state == HIGH) && r_s1 &&
                      (r_rep_first ? (r_rep_cnt == REP_DLY) : (r_rep_cnt == REP_PER));

  // Repeat counter: holds cycles since the last press pulse while in HIGH.
  // Outside HIGH it is preloaded to 1 so the count is already aligned on
  // the edge that enters HIGH; this also discards any count on leaving HIGH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else if ((r_state == HIGH) && r_s1) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= REP_W'(1);
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
    end else begin
      r_rep_cnt   <= REP_W'(1);
      r_rep_first <= 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Debounce FSM with registered level and one-cycle press/release pulses
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        LOW: begin
          if (r_s1) begin
            r_state <= CHK_HIGH;
            r_cnt   <= CNT_W'(1);
          end
        end
        CHK_HIGH: begin
          if (!r_s1) begin
            r_state <= LOW;
            r_cnt   <= '0;
          end else if (r_cnt == DB_CNT) begin
            r_state <= HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!r_s1) begin
            r_state <= CHK_LOW;
            r_cnt   <= CNT_W'(1);
          end else if (w_rep_fire) begin
            r_press <= 1'b1;
          end
        end
        CHK_LOW: begin
          if (r_s1) begin
            r_state <= HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == DB_CNT) begin
            r_state   <= LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent push-button debouncers. Each channel is
// synchronised, debounced and turned into a clean level plus one-cycle
// press/release pulses. Define BTN_COND_REPEAT_EN to add auto-repeat
// press pulses while a button is held.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN         = 6,
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  btn_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;

  // Zero stable time or zero repeat spacing has no meaningful behaviour
  if (DB_CYCLES == 0) begin : g_bad_db
    $error("btn_conditioner: DB_CYCLES must be >= 1");
  end
  if ((REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_rep
    $error("btn_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_COND_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_raw     (bus.btn_raw[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed bench for btn_conditioner with DB_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Define BTN_COND_REPEAT_EN to exercise
// the auto-repeat build; otherwise a single press per hold is expected.
module tb_btn_conditioner;

  localparam int unsigned N   = 6;
  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN         (N),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_raw = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.btn_level !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_level: got %h required %h", bus.btn_level, 6'h00);
    end
    n_checks++;
    if (bus.btn_press !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_press: got %h required %h", bus.btn_press, 6'h00);
    end
    n_checks++;
    if (bus.btn_release !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_release: got %h required %h", bus.btn_release, 6'h00);
    end
    // raw[1] rises, sampled at edge k = next edge; press at k+6 only
    bus.btn_raw[1] = 1'b1;
    for (int t = 0; t <= 7; t++) begin
      tick();
      n_checks++;
      if (bus.btn_press[1] !== ((t == 6) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL latency_press1 t=k+%0d: got %b required %b", t, bus.btn_press[1], (t == 6));
      end
      n_checks++;
      if (bus.btn_level[1] !== ((t >= 6) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL latency_level1 t=k+%0d: got %b required %b", t, bus.btn_level[1], (t >= 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    do_reset();
    pat = 4'b0101;
    for (int t = 0; t < 16; t++) begin
      bus.btn_raw[0] = (t < 4) ? pat[3 - t] : 1'b0;
      tick();
      n_checks++;
      if ({bus.btn_press[0], bus.btn_release[0], bus.btn_level[0]} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce t=%0d: got press/rel/lvl %b%b%b required 000",
                 t, bus.btn_press[0], bus.btn_release[0], bus.btn_level[0]);
      end
    end
  endtask

  task automatic test_release();
    int waited;
    do_reset();
    bus.btn_raw[2] = 1'b1;
    waited = 0;
    while (bus.btn_level[2] !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (bus.btn_level[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_setup: level2 got %b required 1 within 20 cycles", bus.btn_level[2]);
    end
    bus.btn_raw[2] = 1'b0;
    for (int t = 0; t <= 7; t++) begin
      tick();
      n_checks++;
      if (bus.btn_release[2] !== ((t == 6) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL release_pulse t=k+%0d: got %b required %b", t, bus.btn_release[2], (t == 6));
      end
      n_checks++;
      if (bus.btn_level[2] !== ((t >= 6) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL release_level t=k+%0d: got %b required %b", t, bus.btn_level[2], (t < 6));
      end
      n_checks++;
      if (bus.btn_press[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL release_nopress t=k+%0d: got %b required 0", t, bus.btn_press[2]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    bus.btn_raw[0] = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_checks++;
      if (bus.btn_press[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_press_in_reset t=%0d: got %b required 0", t, bus.btn_press[0]);
      end
    end
    reset = 1'b0;
    // first edge sampling reset low is tr; press expected at tr+DB+2
    for (int t = 0; t <= int'(DB) + 3; t++) begin
      tick();
      n_checks++;
      if (bus.btn_press[0] !== ((t == int'(DB) + 2) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL midreset_press t=tr+%0d: got %b required %b",
                 t, bus.btn_press[0], (t == int'(DB) + 2));
      end
    end
  endtask

  task automatic test_independence();
    do_reset();
    bus.btn_raw[0] = 1'b1;
    bus.btn_raw[5] = 1'b1;
    for (int t = 0; t <= 9; t++) begin
      tick();
      if (t == 0) bus.btn_raw[5] = 1'b0;
      if (t == 1) bus.btn_raw[5] = 1'b1;
      n_checks++;
      if (bus.btn_press[0] !== ((t == 6) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL indep_press0 t=k+%0d: got %b required %b", t, bus.btn_press[0], (t == 6));
      end
      n_checks++;
      if (bus.btn_press[5] !== ((t == 8) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL indep_press5 t=k+%0d: got %b required %b", t, bus.btn_press[5], (t == 8));
      end
    end
  endtask

  task automatic test_repeat();
    logic exp_p;
    do_reset();
    bus.btn_raw[1] = 1'b1;
    // raw sampled high from edge k; initial press at k+6 (t0)
    for (int t = 0; t <= 35; t++) begin
      tick();
      if (t == 22) bus.btn_raw[1] = 1'b0;
`ifdef BTN_COND_REPEAT_EN
      exp_p = (t == 6) || (t == 16) || (t == 19) || (t == 22);
`else
      exp_p = (t == 6);
`endif
      n_checks++;
      if (bus.btn_press[1] !== exp_p) begin
        n_fail++;
        $display("FAIL repeat_press t=k+%0d: got %b required %b", t, bus.btn_press[1], exp_p);
      end
      n_checks++;
      if (bus.btn_release[1] !== ((t == 29) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL repeat_release t=k+%0d: got %b required %b", t, bus.btn_release[1], (t == 29));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.btn_raw = '0;
    test_reset();
    test_bounce();
    test_release();
    test_reset_mid_count();
    test_independence();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end conditioning stage for the board push-buttons. Synchronises each raw `btn` input to `clk`, debounces it and emits a clean level plus single-cycle press/release pulses. Its outputs feed the `clear`/`start`/`stop` inputs of the reaction timer. Downstream logic can then treat every button as one glitch-free event per physical press.

## Interface
Parameters:
- `N_BTN`, 6, number of button channels.
- `DB_CYCLES`, 2_000_000, required stable time in clocks (20 ms at 100 MHz); legal range ≥ 1.
- `REPEAT_DELAY`, 50_000_000, clocks from press to first auto-repeat; used only with the macro.
- `REPEAT_PERIOD`, 10_000_000, clocks between auto-repeats; used only with the macro.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_raw` in `N_BTN`: asynchronous, bouncing button pins.
- `btn_level` out `N_BTN`: debounced button state.
- `btn_press` out `N_BTN`: one-cycle pulse on a debounced 0→1 transition (and on auto-repeats).
- `btn_release` out `N_BTN`: one-cycle pulse on a debounced 1→0 transition.

## Operation
- All channels are independent and identical.
- Each channel has a 2-FF synchroniser: `s0 <= btn_raw[i]; s1 <= s0`. Only `s1` is used downstream.
- Each channel has a state machine with four states:
  - LOW: `btn_level` = 0.
  - CHK_HIGH: `s1` = 1 observed, counting.
  - HIGH: `btn_level` = 1.
  - CHK_LOW: `s1` = 0 observed, counting.
- State transitions:
  - LOW → CHK_HIGH when `s1` = 1. The counter loads 1.
  - CHK_HIGH: while `s1` = 1, the counter increments. When the counter reaches `DB_CYCLES`, go to HIGH. On that same edge, `btn_level` goes to 1 and `btn_press` pulses.
  - CHK_HIGH: any `s1` = 0 sample returns the channel to LOW and clears the counter. No pulse is emitted.
  - HIGH and CHK_LOW mirror the above with opposite polarity. `btn_release` pulses on entry to LOW.
- Counter width is `$clog2(DB_CYCLES+1)`. The counter saturates and never wraps.
- `btn_press` and `btn_release` are never high together on the same channel.
- Each pulse lasts exactly one cycle.
- Reset sets every register to 0: both synchroniser stages, counters, state = LOW, and all outputs.
- A button held through reset is reported as a fresh press `DB_CYCLES`+2 clocks after `reset` deasserts.
- Reset asserted mid-count discards the partial count. No pulse is emitted.

## Timing
- Latency: a raw edge sampled at edge k, then held stable, appears on `btn_level`/`btn_press` at edge k+2+`DB_CYCLES`. The 2 is the synchroniser; `DB_CYCLES` is the stable-sample count.
- Release latency is identical.
- Bounce shorter than `DB_CYCLES` synchronised samples produces no output change.
- All outputs are registered, so there is no combinational path from `btn_raw`.

## Configuration
- `BTN_COND_REPEAT_EN` defined:
  - While a channel stays in HIGH, `btn_press` pulses again `REPEAT_DELAY` clocks after the initial press pulse.
  - After that, it pulses every `REPEAT_PERIOD` clocks.
  - Leaving HIGH (entering CHK_LOW) resets the repeat counter. A bounce back to HIGH does not emit a pulse.
  - Repeat counter width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`.
- `BTN_COND_REPEAT_EN` undefined:
  - No repeat counter is synthesised and the repeat parameters are ignored.
  - Exactly one `btn_press` per debounced rise.

## Structure
- Package `btn_cond_pkg` contains:
  - The channel state enum `btn_state_t` {LOW, CHK_HIGH, HIGH, CHK_LOW}.
  - Default constants: `DB_CYCLES_DEF`, `REPEAT_DELAY_DEF`, `REPEAT_PERIOD_DEF`.
- Sub-module `btn_debounce_ch` contains one channel: synchroniser, FSM, debounce counter and optional repeat counter.
- The top generates `N_BTN` instances of `btn_debounce_ch`.

## Test plan
All scenarios use `DB_CYCLES`=4.
- Reset behaviour: hold `btn_raw`=6'h00, pulse `reset` → all outputs 0. Then raise `btn_raw[1]` at edge k → `btn_level[1]`=1 and `btn_press[1]`=1 at edge k+6 only, `btn_press[1]`=0 at k+7.
- Bounce rejection: toggle `btn_raw[0]` 1,0,1,0 on consecutive clocks, then hold at 0 → no pulses, `btn_level[0]` stays 0.
- Release: press `btn_raw[2]` until `btn_level[2]`=1, then drop it at edge k → `btn_release[2]` pulses at k+6 and `btn_level[2]`=0.
- Reset mid-count: raise `btn_raw[0]`, assert `reset` 3 cycles later → no press pulse. After deassert, with the input still high, `btn_press[0]` pulses exactly `DB_CYCLES`+2 clocks after `reset` falls.
- Channel independence: raise `btn_raw[0]` and `btn_raw[5]` on the same edge, with `btn_raw[5]` bouncing once → `btn_press[0]` arrives on time and `btn_press[5]` is delayed by the restarted count.
- Auto-repeat (with `BTN_COND_REPEAT_EN`, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3): hold `btn_raw[1]` → press pulses at t0, t0+10, t0+13, t0+16. Release → the pulses stop.
